stream_join_n: RTL

- N-channel generalisation of the two-input stream join.
- Each input channel has its own FIFO. One output beat is formed from the head of every enabled channel, and only when all enabled heads are present.
- Output is a registered stage: o_valid and o_data come from flops and stay stable while stalled, and back-to-back beats run at full rate.
- Used wherever several producers must be merged into one concatenated word, e.g. operand gathering ahead of the compute datapath.

---
 rtl/stream_join_pkg.sv | 16 +
 rtl/sync_fifo.sv | 58 +++++
 rtl/stream_join_n.sv | 117 +++++++++++
 3 files changed

// File: rtl/stream_join_pkg.sv
// Shared helpers for the N-channel stream join: FIFO depth, channel slicing, level type.
// Level type macro: STREAM_JOIN_LEVEL_T(addr_sz) expands to logic [addr_sz:0].
`define STREAM_JOIN_LEVEL_T(addr_sz) logic [(addr_sz):0]

package stream_join_pkg;

  function automatic int unsigned depth(input int unsigned addr_sz);
    return 32'd1 << addr_sz;
  endfunction

  // LSB of channel ch inside a packed multi-channel bus
  function automatic int unsigned ch_lsb(input int unsigned ch, input int unsigned width);
    return ch * width;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with full/empty flags and an occupancy count that can represent "full".
// Writes while full and reads while empty are ignored.
module sync_fifo
  import stream_join_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned ADDR_SZ = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_wr,
  input  logic [WIDTH-1:0]   i_data,
  output logic               o_full,
  input  logic               i_rd,
  output logic [WIDTH-1:0]   o_data,
  output logic               o_empty,
  output logic [ADDR_SZ:0]   o_count
);

  localparam int unsigned Depth = depth(ADDR_SZ);
  localparam `STREAM_JOIN_LEVEL_T(ADDR_SZ) FullLvl = (ADDR_SZ + 1)'(Depth);

  logic [WIDTH-1:0]             r_mem [Depth];
  logic [ADDR_SZ-1:0]           r_wr_ptr;
  logic [ADDR_SZ-1:0]           r_rd_ptr;
  `STREAM_JOIN_LEVEL_T(ADDR_SZ) r_count;
  logic                         w_push;
  logic                         w_pop;

  assign o_full  = (r_count == FullLvl);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];
  assign w_push  = i_wr && !o_full;
  assign w_pop   = i_rd && !o_empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Storage needs no reset: pointers and count define what is valid
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/stream_join_n.sv
// N-channel stream join: per-channel FIFOs feed one registered output beat built from all
// enabled heads. Optional statistics outputs are enabled by defining STREAM_JOIN_N_STATS_EN.
module stream_join_n
  import stream_join_pkg::*;
#(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned FIFO_ADDR_SZ = 2,
  parameter int unsigned CNT_W        = 32
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [NUM_CH-1:0]                  i_valid,
  output logic [NUM_CH-1:0]                  i_ready,
  input  logic [NUM_CH*WIDTH-1:0]            i_data,
  input  logic [NUM_CH-1:0]                  i_ch_en,
  output logic                               o_valid,
  input  logic                               o_ready,
  output logic [NUM_CH*WIDTH-1:0]            o_data,
`ifdef STREAM_JOIN_N_STATS_EN
  output logic [CNT_W-1:0]                   o_beat_count,
  output logic [CNT_W-1:0]                   o_starve_count,
  output logic [NUM_CH-1:0]                  o_full_seen,
`endif
  output logic [NUM_CH*(FIFO_ADDR_SZ+1)-1:0] o_level
);

  localparam int unsigned LvlW = FIFO_ADDR_SZ + 1;

  if (NUM_CH < 2 || CNT_W == 0) begin : g_param_check
    $error("stream_join_n: NUM_CH must be >= 2 and CNT_W nonzero");
  end

  logic [NUM_CH-1:0]       w_full;
  logic [NUM_CH-1:0]       w_empty;
  logic [NUM_CH-1:0]       w_push;
  logic [NUM_CH-1:0]       w_pop;
  logic [NUM_CH*WIDTH-1:0] w_head;
  logic [NUM_CH*WIDTH-1:0] w_join;
  logic                    w_heads_ok;
  logic                    w_fire;
  logic                    r_valid;
  logic [NUM_CH*WIDTH-1:0] r_data;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    sync_fifo #(
      .WIDTH  (WIDTH),
      .ADDR_SZ(FIFO_ADDR_SZ)
    ) u_fifo (
      .clk    (clk),
      .reset_n(reset_n),
      .i_wr   (w_push[c]),
      .i_data (i_data[ch_lsb(c, WIDTH) +: WIDTH]),
      .o_full (w_full[c]),
      .i_rd   (w_pop[c]),
      .o_data (w_head[ch_lsb(c, WIDTH) +: WIDTH]),
      .o_empty(w_empty[c]),
      .o_count(o_level[ch_lsb(c, LvlW) +: LvlW])
    );
  end

  assign i_ready = ~w_full;
  assign w_push  = i_valid & ~w_full;
  assign w_pop   = i_ch_en & {NUM_CH{w_fire}};

  // A disabled channel never blocks the join, but at least one channel must be enabled
  assign w_heads_ok = &(~i_ch_en | ~w_empty);
  assign w_fire     = w_heads_ok && (|i_ch_en) && (!r_valid || o_ready);

  always_comb begin
    w_join = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (i_ch_en[c]) w_join[c*WIDTH +: WIDTH] = w_head[c*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (w_fire) begin
      r_valid <= 1'b1;
      r_data  <= w_join;
    end else if (r_valid && o_ready) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

`ifdef STREAM_JOIN_N_STATS_EN
  logic [CNT_W-1:0]  r_beat_count;
  logic [CNT_W-1:0]  r_starve_count;
  logic [NUM_CH-1:0] r_full_seen;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_beat_count   <= '0;
      r_starve_count <= '0;
      r_full_seen    <= '0;
    end else begin
      if (r_valid && o_ready && !(&r_beat_count)) r_beat_count <= r_beat_count + 1'b1;
      if (o_ready && !r_valid && (|i_ch_en) && !(&r_starve_count)) begin
        r_starve_count <= r_starve_count + 1'b1;
      end
      r_full_seen <= r_full_seen | w_full;
    end
  end

  assign o_beat_count   = r_beat_count;
  assign o_starve_count = r_starve_count;
  assign o_full_seen    = r_full_seen;
`endif

endmodule
